// File: rtl/lfsr_ram_check_seq.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_ram_check_seq
// Purpose  : Fills a RAM with LFSR words, then replays every word through a
//            bit-flow checker and counts the words it flags as erroneous.
//            Define LFSR_RAM_SEQ_TIMEOUT_EN to abort a run when the checker
//            does not answer within 16 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_ram_check_seq #(
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    output logic              o_lfsr_en,
    input  logic [2:0]        i_lfsr_data,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [2:0]        o_ram_wdata,
    input  logic [2:0]        i_ram_rdata,
    output logic [2:0]        o_chk_data,
    output logic              o_chk_flag,
    input  logic              i_chk_err,
    input  logic              i_chk_done,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W:0]   o_err_cnt,
    output logic              o_timeout
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_err_one   = (ADDR_W + 1)'(1);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_fill      = 3'd1;
    localparam logic [2:0] c_st_rd_addr   = 3'd2;
    localparam logic [2:0] c_st_rd_wait   = 3'd3;
    localparam logic [2:0] c_st_check     = 3'd4;
    localparam logic [2:0] c_st_wait_done = 3'd5;
    localparam logic [2:0] c_st_gap       = 3'd6;
    localparam logic [2:0] c_st_finish    = 3'd7;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_chk_data;
    logic [ADDR_W:0]   r_err_cnt;
    logic              w_timeout_hit;

    // The address stays fixed from RD_ADDR through GAP, so one counter serves
    // both the RAM read port and the end-of-run test.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state    <= c_st_idle;
            r_addr     <= '0;
            r_chk_data <= '0;
            r_err_cnt  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (i_start) begin
                        r_state   <= c_st_fill;
                        r_addr    <= '0;
                        r_err_cnt <= '0;
                    end
                end
                c_st_fill: begin
                    r_addr <= r_addr + c_addr_one;
                    if (r_addr == c_last_addr) begin
                        r_state <= c_st_rd_addr;
                    end
                end
                c_st_rd_addr: begin
                    r_state <= c_st_rd_wait;
                end
                c_st_rd_wait: begin
                    r_chk_data <= i_ram_rdata;
                    r_state    <= c_st_check;
                end
                c_st_check: begin
                    r_state <= c_st_wait_done;
                end
                c_st_wait_done: begin
                    if (i_chk_done) begin
                        if (i_chk_err) begin
                            r_err_cnt <= r_err_cnt + c_err_one;
                        end
                        r_state <= c_st_gap;
                    end else if (w_timeout_hit) begin
                        r_state <= c_st_finish;
                    end
                end
                c_st_gap: begin
                    if (r_addr == c_last_addr) begin
                        r_state <= c_st_finish;
                    end else begin
                        r_addr  <= r_addr + c_addr_one;
                        r_state <= c_st_rd_addr;
                    end
                end
                c_st_finish: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

`ifdef LFSR_RAM_SEQ_TIMEOUT_EN
    logic [3:0] r_to_cnt;
    logic       r_timeout;

    // Counter value equals the number of whole cycles already spent in
    // WAIT_DONE, so the 16th silent cycle is the one that sees 4'hF.
    assign w_timeout_hit = (r_state == c_st_wait_done) && !i_chk_done && (r_to_cnt == 4'hF);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state == c_st_idle) && i_start) begin
                r_timeout <= 1'b0;
            end else if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end

            if (r_state != c_st_wait_done) begin
                r_to_cnt <= '0;
            end else if (!i_chk_done) begin
                r_to_cnt <= r_to_cnt + 4'd1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign o_timeout     = 1'b0;
`endif

    assign o_ram_we    = (r_state == c_st_fill);
    assign o_lfsr_en   = (r_state == c_st_fill);
    assign o_ram_wdata = i_lfsr_data;
    assign o_ram_addr  = r_addr;
    assign o_chk_data  = r_chk_data;
    assign o_chk_flag  = (r_state == c_st_check);
    assign o_busy      = (r_state != c_st_idle);
    assign o_done      = (r_state == c_st_finish);
    assign o_err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_ram_check_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_ram_check_seq
// Purpose  : Scoreboard bench with LFSR, RAM and checker models (ADDR_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_ram_check_seq;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              lfsr_en;
    logic [2:0]        lfsr_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [2:0]        ram_wdata;
    logic [2:0]        ram_rdata = 3'd0;
    logic [2:0]        chk_data;
    logic              chk_flag;
    logic              chk_err = 1'b0;
    logic              chk_done = 1'b0;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   err_cnt;
    logic              timeout;

    int total = 0;
    int bad   = 0;

    logic [2:0] pat [4];
    logic [2:0] mem [4];
    logic [2:0] widx = 3'd0;

    logic       c_busy = 1'b0;
    int         c_cnt = 0;
    logic [2:0] c_data = 3'd0;
    logic       never_done = 1'b0;
    int         chk_delay = 2;

    logic [2:0] sb_q [$];
    logic [2:0] sb_exp;
    logic [2:0] held = 3'd0;
    logic       prev_flag = 1'b0;
    int         flag_cnt = 0;
    int         done_cnt = 0;

    lfsr_ram_check_seq #(.ADDR_W(ADDR_W)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_start     (start),
        .o_lfsr_en   (lfsr_en),
        .i_lfsr_data (lfsr_data),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata),
        .o_chk_data  (chk_data),
        .o_chk_flag  (chk_flag),
        .i_chk_err   (chk_err),
        .i_chk_done  (chk_done),
        .o_busy      (busy),
        .o_done      (done),
        .o_err_cnt   (err_cnt),
        .o_timeout   (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // LFSR model: serves the pattern table, one word per enable
    assign lfsr_data = pat[widx[1:0]];
    always @(posedge clk) begin
        if (!busy) widx <= 3'd0;
        else if (lfsr_en) widx <= widx + 3'd1;
    end

    // RAM model: synchronous write, one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Checker model: flags 3'b111 as erroneous after chk_delay cycles
    always @(posedge clk) begin
        chk_done <= 1'b0;
        if (!rstn) begin
            c_busy <= 1'b0;
            chk_err <= 1'b0;
        end else if (chk_flag) begin
            c_busy <= 1'b1;
            c_cnt  <= chk_delay;
            c_data <= chk_data;
        end else if (c_busy && !never_done) begin
            if (c_cnt == 0) begin
                chk_done <= 1'b1;
                chk_err  <= (c_data == 3'b111);
                c_busy   <= 1'b0;
            end else begin
                c_cnt <= c_cnt - 1;
            end
        end
    end

    // Scoreboard side: every flag pops one expected word
    always @(negedge clk) begin
        if (chk_flag) begin
            flag_cnt++;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_chk_data: got %0h want none", chk_data);
            end else begin
                sb_exp = sb_q.pop_front();
                if (chk_data !== sb_exp) begin
                    bad++;
                    $display("FAIL sb_chk_data: got %0h want %0h", chk_data, sb_exp);
                end
            end
            total++;
            if (prev_flag) begin
                bad++;
                $display("FAIL flag_width: got 2+ cycles want 1");
            end
            held = chk_data;
        end
        if (chk_done && busy) begin
            total++;
            if (chk_data !== held) begin
                bad++;
                $display("FAIL chk_data_stable: got %0h want %0h", chk_data, held);
            end
        end
        if (done) done_cnt++;
        prev_flag = chk_flag;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_pat();
        for (int i = 0; i < 4; i++) sb_q.push_back(pat[i]);
    endtask

    function automatic int n_err();
        int n = 0;
        for (int i = 0; i < 4; i++) if (pat[i] == 3'b111) n++;
        return n;
    endfunction

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_flag(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (chk_flag) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0;
        tick(); tick();
        total++; if (ram_addr !== '0) begin bad++; $display("FAIL rst_addr: got %0d want 0", ram_addr); end
        total++; if (chk_data !== '0) begin bad++; $display("FAIL rst_chk_data: got %0d want 0", chk_data); end
        total++; if (err_cnt !== '0) begin bad++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %0b want 0", timeout); end
        total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL rst_done_busy: got %b want 00", {done, busy}); end
        total++; if ({ram_we, lfsr_en, chk_flag} !== 3'b000) begin
            bad++; $display("FAIL rst_strobes: got %b want 000", {ram_we, lfsr_en, chk_flag});
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_fill_and_check();
        bit seen;
        int f0;
        pat = '{3'b010, 3'b111, 3'b111, 3'b001};
        chk_delay = 2; never_done = 1'b0;
        f0 = flag_cnt;
        push_pat();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({ram_we, lfsr_en} !== 2'b11 || ram_addr !== ADDR_W'(i) || ram_wdata !== pat[i]) begin
                bad++;
                $display("FAIL fill_%0d: got we/en=%b addr=%0d wdata=%0h want 11 %0d %0h",
                         i, {ram_we, lfsr_en}, ram_addr, ram_wdata, i, pat[i]);
            end
            tick();
        end
        total++;
        if (ram_we !== 1'b0 || ram_addr !== '0 || busy !== 1'b1) begin
            bad++; $display("FAIL rd_addr_entry: got we=%b addr=%0d busy=%b want 0 0 1", ram_we, ram_addr, busy);
        end
        wait_done(seen);
        total++; if (!seen) begin bad++; $display("FAIL fill_done: got no done want done"); end
        total++; if (err_cnt !== (ADDR_W+1)'(n_err())) begin bad++; $display("FAIL fill_err_cnt: got %0d want %0d", err_cnt, n_err()); end
        tick();
        total++; if (flag_cnt - f0 !== 4) begin bad++; $display("FAIL fill_flags: got %0d want 4", flag_cnt - f0); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL fill_idle: got busy=%b done=%b want 0 0", busy, done); end
        total++; if (err_cnt !== 3'd2) begin bad++; $display("FAIL fill_err_hold: got %0d want 2", err_cnt); end
    endtask

    task automatic test_start_ignored();
        bit seen;
        int d0;
        pat = '{3'b111, 3'b111, 3'b111, 3'b000};
        chk_delay = 5; never_done = 1'b0;
        push_pat();
        start = 1'b1; tick(); start = 1'b0;
        d0 = done_cnt;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_flag(seen);
        total++; if (!seen) begin bad++; $display("FAIL ign_flag: got no flag want flag"); end
        tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(seen);
        total++; if (!seen) begin bad++; $display("FAIL ign_done: got no done want done"); end
        total++; if (err_cnt !== 3'd3) begin bad++; $display("FAIL ign_err_cnt: got %0d want 3", err_cnt); end
        repeat (4) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_restart: got busy=%b want 0", busy); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt - d0); end
        total++; if (err_cnt !== 3'd3) begin bad++; $display("FAIL ign_err_hold: got %0d want 3", err_cnt); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int n;
        pat = '{3'b111, 3'b111, 3'b010, 3'b010};
        chk_delay = 5; never_done = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        rstn = 1'b0; tick(); rstn = 1'b1;
        total++; if (busy !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0) begin
            bad++; $display("FAIL rst_fill: got busy=%b we=%b addr=%0d want 0 0 0", busy, ram_we, ram_addr);
        end
        push_pat();
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && n < 2; i++) begin
            tick();
            if (chk_flag) n++;
        end
        total++; if (n != 2) begin bad++; $display("FAIL rst_mid_flags: got %0d want 2", n); end
        tick();
        total++; if (err_cnt !== 3'd1) begin bad++; $display("FAIL rst_mid_pre: got %0d want 1", err_cnt); end
        rstn = 1'b0; tick(); rstn = 1'b1;
        sb_q.delete();
        total++; if (busy !== 1'b0 || err_cnt !== '0 || chk_data !== '0) begin
            bad++; $display("FAIL rst_wait_done: got busy=%b err=%0d data=%0h want 0 0 0", busy, err_cnt, chk_data);
        end
        push_pat();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(seen);
        total++; if (!seen || err_cnt !== 3'd2) begin
            bad++; $display("FAIL rst_rerun: got done=%b err=%0d want 1 2", seen, err_cnt);
        end
        tick();
    endtask

    task automatic test_timeout();
        bit seen;
        int early;
        pat = '{3'b001, 3'b010, 3'b011, 3'b100};
        never_done = 1'b1;
        push_pat();
        start = 1'b1; tick(); start = 1'b0;
        wait_flag(seen);
        total++; if (!seen) begin bad++; $display("FAIL to_flag: got no flag want flag"); end
`ifdef LFSR_RAM_SEQ_TIMEOUT_EN
        early = 0;
        for (int k = 1; k < 17; k++) begin
            tick();
            if (done) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL to_early_done: got %0d want 0", early); end
        tick();
        total++; if (done !== 1'b1 || timeout !== 1'b1) begin
            bad++; $display("FAIL to_fire: got done=%b timeout=%b want 1 1", done, timeout);
        end
        tick();
        total++; if (busy !== 1'b0 || timeout !== 1'b1) begin
            bad++; $display("FAIL to_idle: got busy=%b timeout=%b want 0 1", busy, timeout);
        end
        sb_q.delete();
        never_done = 1'b0;
        push_pat();
        start = 1'b1; tick(); start = 1'b0;
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_clear: got %b want 0", timeout); end
        wait_done(seen);
        total++; if (!seen || err_cnt !== '0) begin
            bad++; $display("FAIL to_rerun: got done=%b err=%0d want 1 0", seen, err_cnt);
        end
        tick();
`else
        early = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) early++;
        end
        total++; if (busy !== 1'b1 || timeout !== 1'b0 || early != 0) begin
            bad++; $display("FAIL no_to_wait: got busy=%b timeout=%b dones=%0d want 1 0 0", busy, timeout, early);
        end
        rstn = 1'b0; tick(); rstn = 1'b1;
        sb_q.delete();
        never_done = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL no_to_recover: got busy=%b want 0", busy); end
        tick();
`endif
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            pat[i] = 3'd0;
            mem[i] = 3'd0;
        end
        test_reset();
        test_fill_and_check();
        test_start_ignored();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_ram_check_seq.md
LFSR_RAM_CHECK_SEQ -- requirements
Module: lfsr_ram_check_seq

Interface
REQ-001 Parameter: ADDR_W, default 4, RAM address width; DEPTH = 2**ADDR_W words of 3 bits.
REQ-002 i_clk  in  1  sole clock, all state updates on rising edge.
REQ-003 i_rstn  in  1  reset, synchronous, active-low.
REQ-004 i_start  in  1  run request, sampled only in IDLE.
REQ-005 o_lfsr_en  out  1  LFSR advance enable.
REQ-006 i_lfsr_data  in  3  current LFSR word.
REQ-007 o_ram_we  out  1  RAM write enable.
REQ-008 o_ram_addr  out  ADDR_W  RAM address for both write and read.
REQ-009 o_ram_wdata  out  3  RAM write data.
REQ-010 i_ram_rdata  in  3  RAM read data, valid one cycle after address is presented.
REQ-011 o_chk_data  out  3  word presented to the bit-flow checker.
REQ-012 o_chk_flag  out  1  one-cycle checker start pulse.
REQ-013 i_chk_err  in  1  checker result, valid only while i_chk_done=1.
REQ-014 i_chk_done  in  1  checker result-valid pulse.
REQ-015 o_busy  out  1  high in every state except IDLE.
REQ-016 o_done  out  1  one-cycle pulse at end of a run.
REQ-017 o_err_cnt  out  ADDR_W+1  number of words flagged erroneous in the last run.
REQ-018 o_timeout  out  1  sticky checker-timeout indication (see Configuration).

Function
REQ-019 The FSM SHALL use states IDLE, FILL, RD_ADDR, RD_WAIT, CHECK, WAIT_DONE, GAP, FINISH.
REQ-020 IDLE: on i_start=1 -> FILL; address counter, o_err_cnt and o_timeout cleared in the same edge.
REQ-021 FILL: o_ram_we=1, o_lfsr_en=1, o_ram_wdata=i_lfsr_data (combinational), one write per cycle at addresses 0..DEPTH-1; after writing DEPTH-1, address wraps to 0 -> RD_ADDR.
REQ-022 RD_ADDR: drive o_ram_addr, no write -> RD_WAIT.
REQ-023 RD_WAIT: capture i_ram_rdata into o_chk_data register -> CHECK.
REQ-024 CHECK: o_chk_flag=1 for exactly one cycle; o_chk_data held stable from CHECK until exit of WAIT_DONE -> WAIT_DONE.
REQ-025 WAIT_DONE: on i_chk_done=1, sample i_chk_err; if 1, o_err_cnt increments by 1 -> GAP.
REQ-026 GAP: exactly one idle cycle so the checker returns to its start state before the next flag; if address = DEPTH-1 -> FINISH, else address+1 -> RD_ADDR.
REQ-027 FINISH: o_done=1 for one cycle -> IDLE; o_err_cnt held until the next accepted i_start.
REQ-028 o_err_cnt width ADDR_W+1 SHALL hold DEPTH without overflow; no saturation logic.
REQ-029 i_start while o_busy=1 SHALL be ignored; i_chk_done outside WAIT_DONE SHALL be ignored.
REQ-030 o_ram_we, o_lfsr_en, o_chk_flag SHALL be 0 in every state other than those listed above.

Reset
REQ-031 i_rstn=0 at a rising edge SHALL force IDLE from any state, including mid-FILL and mid-WAIT_DONE.
REQ-032 Reset values: o_ram_addr=0, o_chk_data=0, o_err_cnt=0, o_timeout=0, o_done=0, o_busy=0, o_ram_we=0, o_lfsr_en=0, o_chk_flag=0.

Configuration
REQ-033 Macro LFSR_RAM_SEQ_TIMEOUT_EN: defined -> a 4-bit counter runs in WAIT_DONE; if 16 cycles pass without i_chk_done, o_timeout=1, o_done pulses, state -> IDLE (abort run).
REQ-034 Undefined -> no counter, WAIT_DONE waits indefinitely, o_timeout tied 0.

Verification
REQ-035 Reset: hold i_rstn=0 two cycles -> all outputs at REQ-032 values, o_busy=0.
REQ-036 ADDR_W=2, i_start pulse -> 4 consecutive cycles o_ram_we=1, o_lfsr_en=1, o_ram_addr 0,1,2,3, then RD_ADDR at address 0.
REQ-037 RAM model holding 3'b010,3'b111,3'b111,3'b001, checker model err=1 only for 3'b111 -> four single-cycle o_chk_flag pulses, o_done pulse, o_err_cnt=2.
REQ-038 i_start asserted during FILL and WAIT_DONE -> no restart, single o_done, o_err_cnt unchanged by it.
REQ-039 Checker model never asserts done, macro defined -> o_timeout=1 and o_done 16 cycles after WAIT_DONE entry, then IDLE; macro undefined -> o_busy stays 1.
REQ-040 i_rstn=0 for one cycle during WAIT_DONE of word 2 -> IDLE next cycle, o_err_cnt=0; fresh i_start completes a full run normally.
